// File: rtl/mc_defs_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encodings,
// opcodes, datapath select codes and the decoded control word.
package mc_defs;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_ADDI) ||
           (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control-word decoder for the multi-cycle FSM.
module mc_outdec
  import mc_defs::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.instr_done = ~is_known_op(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.instr_done = 1'b1;
        ctrl.pc_en      = ((opcode == OP_BEQ) &  zero) |
                          ((opcode == OP_BNE) & ~zero);
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_en      = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-ALU / unified-memory multi-cycle MIPS core.
// Holds the state register and next-state logic; outputs come from mc_outdec.
module multicycle_control
  import mc_defs::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               memReady,
  output logic               pcEn,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               irWrite,
  output logic               memtoReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [2:0]         aluOp,
  output logic [1:0]         pcSource,
  output logic               instrDone,
  output logic [STATE_W-1:0] state
);

  state_t cur_state;
  state_t nxt_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:       nxt_state = S_EXEC;
          OP_LW, OP_SW:   nxt_state = S_MEMADR;
          OP_BEQ, OP_BNE: nxt_state = S_BRANCH;
          OP_ADDI:        nxt_state = S_ADDIEX;
          OP_J:           nxt_state = S_JUMP;
          default:        nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  nxt_state = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt_state = memReady ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt_state = S_RWB;
      S_ADDIEX: nxt_state = S_ADDIWB;
      default:  nxt_state = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (cur_state),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (memReady),
    .ctrl      (ctrl)
  );

  // Reset suppresses every architectural write, even mid-instruction.
  always_comb begin
    pcEn      = ctrl.pc_en     & ~reset;
    irWrite   = ctrl.ir_write  & ~reset;
    regWrite  = ctrl.reg_write & ~reset;
    memWrite  = ctrl.mem_write & ~reset;
    iorD      = ctrl.ior_d;
    memRead   = ctrl.mem_read;
    memtoReg  = ctrl.mem_to_reg;
    regDst    = ctrl.reg_dst;
    aluSrcA   = ctrl.alu_src_a;
    aluSrcB   = ctrl.alu_src_b;
    aluOp     = ctrl.alu_op;
    pcSource  = ctrl.pc_source;
    instrDone = ctrl.instr_done;
  end

  assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, an sw memory-wait
// sequence, then randomized instruction streams against a behavioural model.
module tb_multicycle_control;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       memReady;
  logic       pcEn, iorD, memRead, memWrite, irWrite, memtoReg, regDst;
  logic       regWrite, aluSrcA, instrDone;
  logic [1:0] aluSrcB, pcSource;
  logic [2:0] aluOp;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcEn(pcEn), .iorD(iorD), .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .memtoReg(memtoReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .instrDone(instrDone), .state(state)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  logic [3:0]  we;
  assign obs = {pcEn, iorD, memRead, memWrite, irWrite, memtoReg, regDst, regWrite,
                aluSrcA, aluSrcB, aluOp, pcSource, instrDone};
  assign we  = {pcEn, irWrite, regWrite, memWrite};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs mid-cycle; outputs are settled and sampled 1ns later.
  task automatic apply(input logic r, input logic [5:0] op, input logic z, input logic mr);
    @(negedge clk);
    reset = r; opcode = op; zero = z; memReady = mr;
    #1;
  endtask

  // Expected control word from the state-by-state output table.
  function automatic logic [16:0] model_out(input int st, input logic [5:0] op,
                                            input logic z, input logic mr, input logic r);
    logic pe = 0, io = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, dn = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ao = 3'b000;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
      1:  begin sb = 2'b11;
                dn = !(op == T_RTYPE || op == T_LW || op == T_SW || op == T_BEQ ||
                       op == T_BNE || op == T_ADDI || op == T_J); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mwr = 1; io = 1; dn = mr; end
      6:  begin sa = 1; ao = 3'b010; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 3'b001; ps = 2'b01; dn = 1;
                pe = (op == T_BEQ && z) || (op == T_BNE && !z); end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; dn = 1; end
      11: begin pe = 1; ps = 2'b10; dn = 1; end
      default: ;
    endcase
    if (r) begin pe = 0; irw = 0; rw = 0; mwr = 0; end
    return {pe, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, dn};
  endfunction

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    int         st;
    logic [3:0] we;   // {pcEn, irWrite, regWrite, memWrite}
    logic       done;
  } vec_t;

  vec_t vt[$];

  function automatic void row(input logic r, input logic [5:0] op, input logic z,
                              input logic mr, input int st, input logic [3:0] w,
                              input logic d);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.we = w; v.done = d;
    vt.push_back(v);
  endfunction

  int          phases[$];
  logic [5:0]  cur_op;

  // Instruction-level model: the ordered list of visited states for one opcode.
  task automatic new_instr();
    logic [5:0] ops[8] = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_J, T_BAD};
    cur_op = ops[$urandom_range(0, 7)];
    if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom);
    phases = '{0, 1};
    case (cur_op)
      T_RTYPE:      phases = {phases, 6, 7};
      T_LW:         phases = {phases, 2, 3, 4};
      T_SW:         phases = {phases, 2, 5};
      T_BEQ, T_BNE: phases = {phases, 8};
      T_ADDI:       phases = {phases, 9, 10};
      T_J:          phases = {phases, 11};
      default: ;
    endcase
  endtask

  initial begin
    int mw_cnt, rw_cnt, done_cnt, iord_bad;
    reset = 1'b1; opcode = '0; zero = 1'b0; memReady = 1'b1;
    @(posedge clk);

    row(1, T_RTYPE, 0, 1, 0, 4'b0000, 0);
    row(1, T_RTYPE, 0, 1, 0, 4'b0000, 0);
    row(0, T_LW,    0, 1, 0, 4'b1100, 0);
    row(0, T_LW,    0, 1, 1, 4'b0000, 0);
    row(0, T_LW,    0, 1, 2, 4'b0000, 0);
    row(0, T_LW,    0, 1, 3, 4'b0000, 0);
    row(0, T_LW,    0, 1, 4, 4'b0010, 1);
    row(0, T_SW,    0, 1, 0, 4'b1100, 0);
    row(0, T_SW,    0, 1, 1, 4'b0000, 0);
    row(0, T_SW,    0, 1, 2, 4'b0000, 0);
    row(0, T_SW,    0, 0, 5, 4'b0001, 0);
    row(0, T_SW,    0, 0, 5, 4'b0001, 0);
    row(0, T_SW,    0, 1, 5, 4'b0001, 1);
    row(0, T_BEQ,   0, 0, 0, 4'b0000, 0);
    row(0, T_BEQ,   0, 1, 0, 4'b1100, 0);
    row(0, T_BEQ,   1, 1, 1, 4'b0000, 0);
    row(0, T_BEQ,   1, 1, 8, 4'b1000, 1);
    row(0, T_BNE,   1, 1, 0, 4'b1100, 0);
    row(0, T_BNE,   1, 1, 1, 4'b0000, 0);
    row(0, T_BNE,   1, 1, 8, 4'b0000, 1);
    row(0, T_BAD,   0, 1, 0, 4'b1100, 0);
    row(0, T_BAD,   0, 1, 1, 4'b0000, 1);
    row(0, T_LW,    0, 1, 0, 4'b1100, 0);
    row(0, T_LW,    0, 1, 1, 4'b0000, 0);
    row(0, T_LW,    0, 1, 2, 4'b0000, 0);
    row(0, T_LW,    0, 0, 3, 4'b0000, 0);
    row(1, T_LW,    0, 1, 3, 4'b0000, 0);
    row(0, T_RTYPE, 0, 1, 0, 4'b1100, 0);
    row(0, T_RTYPE, 0, 1, 1, 4'b0000, 0);
    row(0, T_RTYPE, 0, 1, 6, 4'b0000, 0);
    row(0, T_RTYPE, 0, 1, 7, 4'b0010, 1);
    row(0, T_J,     0, 1, 0, 4'b1100, 0);
    row(0, T_J,     0, 1, 1, 4'b0000, 0);
    row(0, T_J,     0, 1, 11, 4'b1000, 1);
    row(0, T_ADDI,  0, 1, 0, 4'b1100, 0);
    row(0, T_ADDI,  0, 1, 1, 4'b0000, 0);
    row(0, T_ADDI,  0, 1, 9, 4'b0000, 0);
    row(0, T_ADDI,  0, 1, 10, 4'b0010, 1);

    foreach (vt[i]) begin
      apply(vt[i].rst, vt[i].op, vt[i].z, vt[i].mr);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].st));
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vt[i].we));
      chk($sformatf("vec%0d_done", i), 32'(instrDone), 32'(vt[i].done));
      chk($sformatf("vec%0d_word", i), 32'(obs),
          32'(model_out(vt[i].st, vt[i].op, vt[i].z, vt[i].mr, vt[i].rst)));
    end

    // sw with two wait cycles in MEMWR: six cycles, three memWrite cycles.
    mw_cnt = 0; rw_cnt = 0; done_cnt = 0; iord_bad = 0;
    for (int c = 0; c < 6; c++) begin
      apply(0, T_SW, 0, (c == 3 || c == 4) ? 1'b0 : 1'b1);
      if (memWrite) begin
        mw_cnt++;
        if (!iorD) iord_bad++;
      end
      if (regWrite)  rw_cnt++;
      if (instrDone) done_cnt++;
    end
    chk("sw_wait_memwrite_cycles", 32'(mw_cnt), 32'd3);
    chk("sw_wait_iord_low", 32'(iord_bad), 32'd0);
    chk("sw_wait_regwrite", 32'(rw_cnt), 32'd0);
    chk("sw_wait_done_pulses", 32'(done_cnt), 32'd1);
    chk("sw_wait_last_state", 32'(state), 32'd5);
    apply(0, T_RTYPE, 0, 0);
    chk("sw_wait_back_to_fetch", 32'(state), 32'd0);

    // Randomized instruction stream against the instruction-level model.
    phases.delete();
    phases.push_back(0);
    cur_op = T_RTYPE;
    phases = '{0, 1, 6, 7};
    for (int n = 0; n < 3000; n++) begin
      logic r, z, mr;
      logic [5:0] op;
      int ph;
      if (phases.size() == 0) new_instr();
      ph = phases[0];
      r  = ($urandom_range(0, 59) == 0);
      mr = ($urandom_range(0, 3) != 0);
      z  = 1'($urandom);
      op = (ph == 0) ? 6'($urandom) : cur_op;
      apply(r, op, z, mr);
      chk("rand_state", 32'(state), 32'(ph));
      chk("rand_word", 32'(obs), 32'(model_out(ph, op, z, mr, r)));
      if (r) phases.delete();
      else if (!((ph == 0 || ph == 3 || ph == 5) && !mr)) void'(phases.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM that sequences a shared-resource multi-cycle MIPS datapath. One ALU and one unified instruction/data memory are reused across cycles, driven by the same register file, sign-extend and mux primitives as the single-cycle core. The block takes the latched opcode, the ALU zero flag and a memory-ready handshake, and produces every datapath enable and mux select. It replaces the combinational `control` + `branch` pair in the multi-cycle core.

## Interface
Parameters:
- `STATE_W`, 4, state register width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  instruction register bits [31:26]; valid from DECODE onward.
- `zero`  in  1  ALU zero flag; sampled in BRANCH.
- `memReady`  in  1  memory completes the current access this cycle.
- `pcEn`  out  1  PC register load enable; branch condition already folded in.
- `iorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memRead`  out  1  memory read strobe.
- `memWrite`  out  1  memory write strobe.
- `irWrite`  out  1  instruction register load.
- `memtoReg`  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- `regDst`  out  1  write register select: 0 = rt, 1 = rd.
- `regWrite`  out  1  register file write enable.
- `aluSrcA`  out  1  ALU A select: 0 = PC, 1 = register A.
- `aluSrcB`  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `aluOp`  out  3  ALU operation to `ALUcontrol`: 000 = add, 001 = sub, 010 = decode from funct.
- `pcSource`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump address.
- `instrDone`  out  1  one-cycle pulse in the final state of each instruction.
- `state`  out  STATE_W  current state, for debug.

## Operation
- States: FETCH(0), DECODE(1), MEMADR(2), MEMRD(3), MEMWB(4), MEMWR(5), EXEC(6), RWB(7), BRANCH(8), ADDIEX(9), ADDIWB(10), JUMP(11). Encodings 12–15 are illegal and go to FETCH.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=000, pcSource=00.
  - irWrite and pcEn equal memReady.
  - Stays in FETCH while memReady=0; moves to DECODE when memReady=1.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=000. This computes the branch target into ALUOut.
  - Next state by opcode:
    - 000000 → EXEC
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000100 (beq) or 000101 (bne) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - any other opcode → FETCH, treated as a nop; instrDone=1.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: memRead=1, iorD=1. Holds until memReady=1, then goes to MEMWB.
- MEMWB: regWrite=1, memtoReg=1, regDst=0, instrDone=1. Goes to FETCH.
- MEMWR: memWrite=1, iorD=1. Holds until memReady=1. On completion instrDone=1 and goes to FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=010. Goes to RWB.
- RWB: regWrite=1, regDst=1, memtoReg=0, instrDone=1. Goes to FETCH.
- BRANCH:
  - Outputs: aluSrcA=1, aluSrcB=00, aluOp=001, pcSource=01, instrDone=1.
  - pcEn = (beq & zero) | (bne & ~zero), where beq/bne come from the opcode held in the IR.
  - Goes to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=000. Goes to ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memtoReg=0, instrDone=1. Goes to FETCH.
- JUMP: pcEn=1, pcSource=10, instrDone=1. Goes to FETCH.
- Default values: every output not listed for a state is 0.

## Timing
- State register is the only storage. All outputs decode combinationally from `state`, plus memReady (FETCH, MEMWR) and zero/opcode (BRANCH).
- Reset:
  - A cycle with reset=1 loads FETCH.
  - While reset=1, the write enables pcEn, irWrite, regWrite and memWrite are forced to 0 whatever the state.
  - After reset deasserts, outputs are the FETCH values.
  - Reset mid-instruction (including during a memory wait) abandons the instruction; nothing is written in the reset cycle.
- Latency with memReady=1 throughout, in cycles: R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3, unknown opcode 2.
- Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. While waiting, strobes and selects stay stable.
- memReady is ignored in every state other than FETCH, MEMRD and MEMWR.
- The ALU zero flag must be valid in the same BRANCH cycle; the PC loads at the end of that cycle.

## Structure
- Shared package `mc_defs`: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J), aluOp codes, aluSrcB codes, pcSource codes.
- Natural sub-module: `mc_outdec`, a purely combinational state → control-word decoder. The top holds the state register, next-state logic and reset gating of the write enables.

## Test plan
- Reset held 3 cycles, then released with memReady=1 → state=0, memRead=1, irWrite=1, pcEn=1, aluSrcB=01; regWrite=0, memWrite=0 during reset.
- opcode=100011, memReady=1 → state sequence 0,1,2,3,4,0; regWrite=1 and memtoReg=1 only in cycle 5; instrDone pulses once.
- opcode=101011 with memReady low 2 cycles in MEMWR → memWrite=1 for 3 consecutive cycles with iorD=1; 6 cycles total; regWrite never asserted.
- opcode=000100: zero=1 → pcEn=1, pcSource=01 in BRANCH. Same with zero=0 → pcEn=0. opcode=000101 with zero=0 → pcEn=1. Each takes 3 cycles.
- opcode=000000 then 000010 back-to-back → states 0,1,6,7,0,1,11,0; aluOp=010 in EXEC; pcSource=10 and pcEn=1 in JUMP.
- opcode=111111 → states 0,1,0, no write enables. Reset asserted in MEMRD during a wait → state=0 next cycle, no regWrite.
